audio_mixer: RTL and testbench

AUDIO_MIXER -- requirements
Module: audio_mixer

---
 rtl/audio_mixer.sv | 174 +++++++++++++++++
 tb/tb_audio_mixer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
// Module      : audio_mixer
// Description : Multi-channel stereo mixer. Snapshots one frame of channel
//               samples, volumes and routing modes, accumulates one channel
//               per cycle into left/right sums, saturates to the sample range
//               and presents the result on a valid/ready output port.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_mixer #(
  parameter int NUM_CHANNELS = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int VOL_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] ch_sample,
  input  logic [NUM_CHANNELS*VOL_WIDTH-1:0]    ch_volume,
  input  logic [NUM_CHANNELS*2-1:0]            ch_mode,
  output logic signed [SAMPLE_WIDTH-1:0]       out_left,
  output logic signed [SAMPLE_WIDTH-1:0]       out_right,
  output logic                                 clip_left,
  output logic                                 clip_right,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int ACC_W  = SAMPLE_WIDTH + VOL_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int PROD_W = SAMPLE_WIDTH + VOL_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SAT    = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc_left;
  logic signed [ACC_W-1:0]  acc_right;

  logic signed [SAMPLE_WIDTH-1:0] snap_sample [NUM_CHANNELS];
  logic [VOL_WIDTH-1:0]           snap_vol    [NUM_CHANNELS];
  logic [1:0]                     snap_mode   [NUM_CHANNELS];

  logic                           accept;
  logic signed [PROD_W-1:0]       product;
  logic signed [PROD_W-1:0]       scaled;
  logic signed [ACC_W-1:0]        term;
  logic [1:0]                     cur_mode;
  logic signed [SAMPLE_WIDTH-1:0] sat_left;
  logic signed [SAMPLE_WIDTH-1:0] sat_right;
  logic                           sat_clip_left;
  logic                           sat_clip_right;

  // A new frame may start from IDLE, or from OUTPUT in the handshake cycle.
  assign accept = frame_start && ((state == IDLE) || ((state == OUTPUT) && out_ready));
  assign busy   = (state != IDLE);

  generate
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_snap
      // Capture this channel's inputs when a frame is accepted.
      always_ff @(posedge clk) begin
        if (accept) begin
          snap_sample[k] <= ch_sample[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          snap_vol[k]    <= ch_volume[k*VOL_WIDTH +: VOL_WIDTH];
          snap_mode[k]   <= ch_mode[k*2 +: 2];
        end
      end
    end
  endgenerate

  // Scaled contribution of the current channel; >>> floors toward -infinity.
  always_comb begin
    product  = snap_sample[idx] * $signed({1'b0, snap_vol[idx]});
    scaled   = product >>> (VOL_WIDTH - 1);
    term     = ACC_W'(scaled);
    cur_mode = snap_mode[idx];
  end

  // Clamp both accumulators to the signed sample range and flag any change.
  always_comb begin
    sat_left       = acc_left[SAMPLE_WIDTH-1:0];
    sat_clip_left  = 1'b0;
    sat_right      = acc_right[SAMPLE_WIDTH-1:0];
    sat_clip_right = 1'b0;
    if (acc_left > SAT_MAX) begin
      sat_left      = SAT_MAX[SAMPLE_WIDTH-1:0];
      sat_clip_left = 1'b1;
    end else if (acc_left < SAT_MIN) begin
      sat_left      = SAT_MIN[SAMPLE_WIDTH-1:0];
      sat_clip_left = 1'b1;
    end
    if (acc_right > SAT_MAX) begin
      sat_right      = SAT_MAX[SAMPLE_WIDTH-1:0];
      sat_clip_right = 1'b1;
    end else if (acc_right < SAT_MIN) begin
      sat_right      = SAT_MIN[SAMPLE_WIDTH-1:0];
      sat_clip_right = 1'b1;
    end
  end

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      acc_left   <= '0;
      acc_right  <= '0;
      out_left   <= '0;
      out_right  <= '0;
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_start && !accept;
      case (state)
        IDLE: begin
          if (accept) begin
            acc_left  <= '0;
            acc_right <= '0;
            idx       <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (cur_mode[0]) acc_left  <= acc_left + term;
          if (cur_mode[1]) acc_right <= acc_right + term;
          if (idx == LAST_IDX) begin
            state <= SAT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SAT: begin
          out_left   <= sat_left;
          out_right  <= sat_right;
          clip_left  <= sat_clip_left;
          clip_right <= sat_clip_right;
          out_valid  <= 1'b1;
          state      <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              acc_left  <= '0;
              acc_right <= '0;
              idx       <= '0;
              state     <= ACCUM;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_mixer
// Description : Self-checking bench for audio_mixer: directed vector table,
//               randomized frames against a reference model, and hand-written
//               back-pressure, overrun, reset and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_mixer;

  localparam int NCH   = 8;
  localparam int SW    = 16;
  localparam int VW    = 8;
  localparam int UNITY = 1 << (VW - 1);
  localparam int LAT   = NCH + 2;

  typedef struct {
    int s[NCH];
    int vol[NCH];
    int mode[NCH];
    int el;
    int er;
    int ecl;
    int ecr;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    frame_start = 1'b0;
  logic [NCH*SW-1:0]       ch_sample = '0;
  logic [NCH*VW-1:0]       ch_volume = '0;
  logic [NCH*2-1:0]        ch_mode = '0;
  logic signed [SW-1:0]    out_left;
  logic signed [SW-1:0]    out_right;
  logic                    clip_left;
  logic                    clip_right;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    busy;
  logic                    overrun;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[9];

  audio_mixer #(
    .NUM_CHANNELS(NCH),
    .SAMPLE_WIDTH(SW),
    .VOL_WIDTH(VW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .ch_sample(ch_sample),
    .ch_volume(ch_volume),
    .ch_mode(ch_mode),
    .out_left(out_left),
    .out_right(out_right),
    .clip_left(clip_left),
    .clip_right(clip_right),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t zvec();
    vec_t v;
    for (int k = 0; k < NCH; k++) begin
      v.s[k] = 0;
      v.vol[k] = 0;
      v.mode[k] = 0;
    end
    v.el = 0; v.er = 0; v.ecl = 0; v.ecr = 0;
    return v;
  endfunction

  // Reference: floor(sample*vol/unity) per routed channel, sum, then clamp.
  function automatic vec_t model(input vec_t vin);
    vec_t   v;
    longint l, r, p, q, hi, lo;
    v  = vin;
    l  = 0;
    r  = 0;
    hi = (64'sd1 <<< (SW - 1)) - 1;
    lo = -(64'sd1 <<< (SW - 1));
    for (int k = 0; k < NCH; k++) begin
      p = longint'(v.s[k]) * longint'(v.vol[k]);
      q = p / UNITY;
      if (p < 0 && q * UNITY != p) q = q - 1;
      if ((v.mode[k] & 1) != 0) l = l + q;
      if ((v.mode[k] & 2) != 0) r = r + q;
    end
    v.ecl = (l > hi || l < lo) ? 1 : 0;
    v.ecr = (r > hi || r < lo) ? 1 : 0;
    v.el  = int'((l > hi) ? hi : (l < lo) ? lo : l);
    v.er  = int'((r > hi) ? hi : (r < lo) ? lo : r);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = zvec();
    for (int k = 0; k < NCH; k++) begin
      v.s[k]    = int'($urandom_range(65535)) - 32768;
      v.vol[k]  = int'($urandom_range(255));
      v.mode[k] = int'($urandom_range(3));
    end
    return model(v);
  endfunction

  task automatic drive(input vec_t v);
    for (int k = 0; k < NCH; k++) begin
      ch_sample[k*SW +: SW] = SW'(v.s[k]);
      ch_volume[k*VW +: VW] = VW'(v.vol[k]);
      ch_mode[k*2 +: 2]     = 2'(v.mode[k]);
    end
  endtask

  task automatic scramble();
    for (int k = 0; k < NCH; k++) begin
      ch_sample[k*SW +: SW] = SW'($urandom);
      ch_volume[k*VW +: VW] = VW'($urandom);
      ch_mode[k*2 +: 2]     = 2'($urandom);
    end
  endtask

  // Count cycles since acceptance until out_valid, bounded.
  task automatic wait_valid(input string tag, input int start);
    int cnt;
    cnt = start;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, " latency"}, cnt, LAT);
  endtask

  task automatic check_out(input vec_t v, input string tag);
    check({tag, " out_left"},   int'(out_left),   v.el);
    check({tag, " out_right"},  int'(out_right),  v.er);
    check({tag, " clip_left"},  int'(clip_left),  v.ecl);
    check({tag, " clip_right"}, int'(clip_right), v.ecr);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " valid after hs"}, int'(out_valid), 0);
    check({tag, " busy after hs"},  int'(busy), 0);
  endtask

  task automatic do_frame(input vec_t v, input string tag);
    drive(v);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    scramble();
    wait_valid(tag, 1);
    check_out(v, tag);
    check({tag, " no overrun"}, int'(overrun), 0);
    handshake(tag);
  endtask

  initial begin
    vec_t v, w;

    // Directed vectors with hand-computed expectations.
    for (int i = 0; i < 9; i++) tbl[i] = zvec();
    tbl[0].s[0] = 1000;  tbl[0].vol[0] = 128; tbl[0].mode[0] = 3;
    tbl[0].el = 1000; tbl[0].er = 1000;
    tbl[1].s[3] = -1001; tbl[1].vol[3] = 64;  tbl[1].mode[3] = 1;
    tbl[1].el = -501; tbl[1].er = 0;
    for (int k = 0; k < NCH; k++) begin
      tbl[2].s[k] = 30000;  tbl[2].vol[k] = 255; tbl[2].mode[k] = 3;
      tbl[3].s[k] = -30000; tbl[3].vol[k] = 255; tbl[3].mode[k] = 3;
    end
    tbl[2].el = 32767;  tbl[2].er = 32767;  tbl[2].ecl = 1; tbl[2].ecr = 1;
    tbl[3].el = -32768; tbl[3].er = -32768; tbl[3].ecl = 1; tbl[3].ecr = 1;
    tbl[4].s[1] = 32767; tbl[4].vol[1] = 255; tbl[4].mode[1] = 2;
    tbl[4].el = 0; tbl[4].er = 32767; tbl[4].ecr = 1;
    tbl[5].s[0] = -32768; tbl[5].vol[0] = 128; tbl[5].mode[0] = 3;
    tbl[5].s[1] = 32767;  tbl[5].vol[1] = 128; tbl[5].mode[1] = 1;
    tbl[5].el = -1; tbl[5].er = -32768;
    tbl[6].s[0] = -32768; tbl[6].vol[0] = 128; tbl[6].mode[0] = 3;
    tbl[6].s[2] = -1;     tbl[6].vol[2] = 128; tbl[6].mode[2] = 2;
    tbl[6].el = -32768; tbl[6].er = -32768; tbl[6].ecr = 1;
    tbl[7].s[5] = -1; tbl[7].vol[5] = 1; tbl[7].mode[5] = 3;
    tbl[7].el = -1; tbl[7].er = -1;
    tbl[8].s[0] = 32767; tbl[8].vol[0] = 128; tbl[8].mode[0] = 3;
    tbl[8].s[7] = 1;     tbl[8].vol[7] = 128; tbl[8].mode[7] = 3;
    tbl[8].el = 32767; tbl[8].er = 32767; tbl[8].ecl = 1; tbl[8].ecr = 1;

    // Reset state.
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst out_valid", int'(out_valid), 0);
    check("rst busy",      int'(busy), 0);
    check("rst overrun",   int'(overrun), 0);
    check("rst out_left",  int'(out_left), 0);
    check("rst out_right", int'(out_right), 0);
    check("rst clip_left", int'(clip_left), 0);
    check("rst clip_right", int'(clip_right), 0);

    // First frame starts in the first cycle after reset release.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) do_frame(tbl[i], $sformatf("tbl%0d", i));

    // Randomized frames against the model.
    for (int i = 0; i < 20; i++) do_frame(rand_vec(), $sformatf("rnd%0d", i));

    // Back-pressure: hold ready low, reject a frame_start, outputs stable.
    v = rand_vec();
    drive(v);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_valid("bp", 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        scramble();
        frame_start = 1'b1;
      end
      tick();
      frame_start = 1'b0;
      check($sformatf("bp valid %0d", i), int'(out_valid), 1);
      check($sformatf("bp overrun %0d", i), int'(overrun), (i == 1) ? 1 : 0);
      check_out(v, $sformatf("bp hold %0d", i));
    end
    handshake("bp");

    // frame_start during ACCUM is rejected and the frame is unaffected.
    v = rand_vec();
    drive(v);
    frame_start = 1'b1;
    tick();
    scramble();
    tick();
    tick();
    frame_start = 1'b0;
    check("accum overrun", int'(overrun), 1);
    tick();
    check("accum overrun pulse", int'(overrun), 0);
    wait_valid("accum", 4);
    check_out(v, "accum");
    handshake("accum");

    // Reset at ACCUM index 4 discards the frame.
    v = rand_vec();
    drive(v);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy",      int'(busy), 0);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst out_left",  int'(out_left), 0);
    check("midrst out_right", int'(out_right), 0);
    check("midrst clip",      int'(clip_left | clip_right), 0);
    repeat (12) tick();
    check("midrst no output", int'(out_valid), 0);
    do_frame(tbl[8], "postrst");

    // Back-to-back: new frame accepted in the handshake cycle.
    v = rand_vec();
    w = rand_vec();
    drive(v);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_valid("b2b A", 1);
    check_out(v, "b2b A");
    drive(w);
    frame_start = 1'b1;
    out_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    out_ready = 1'b0;
    scramble();
    check("b2b valid low", int'(out_valid), 0);
    check("b2b busy",      int'(busy), 1);
    check("b2b overrun",   int'(overrun), 0);
    wait_valid("b2b B", 1);
    check_out(w, "b2b B");
    handshake("b2b B");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
